chip8_mem_arbiter: RTL and testbench

- Shares the single-port 4 KB Chip-8 program/data RAM among three requesters: program uploader, CPU core and blitter.
- Sits inside the Chip-8 machine between those requesters and the RAM macro.
- Uploader has absolute priority and locks out the other two while an upload is in progress.
- CPU and blitter share the remaining bandwidth round-robin; read data is returned with a fixed, parameterised latency.

---
 rtl/chip8_mem_arbiter_if.sv | 50 +++++
 rtl/chip8_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_arbiter_if.sv
// Bus bundle between the Chip-8 RAM requesters (uploader, CPU, blitter),
// the arbiter and the RAM macro. The slave modport is the arbiter's view.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              uploading;
  logic              up_req;
  logic [ADDR_W-1:0] up_a;
  logic [DATA_W-1:0] up_d;
  logic              up_ack;

  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [DATA_W-1:0] cpu_d;
  logic              cpu_ack, cpu_rvalid;
  logic [DATA_W-1:0] cpu_q;

  logic              blt_req, blt_we;
  logic [ADDR_W-1:0] blt_a;
  logic [DATA_W-1:0] blt_d;
  logic              blt_ack, blt_rvalid;
  logic [DATA_W-1:0] blt_q;

  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [DATA_W-1:0] mem_d;
  logic [DATA_W-1:0] mem_q;
  logic              busy;

  modport slave (
    input  uploading, up_req, up_a, up_d,
    input  cpu_req, cpu_we, cpu_a, cpu_d,
    input  blt_req, blt_we, blt_a, blt_d,
    input  mem_q,
    output up_ack, cpu_ack, cpu_rvalid, cpu_q,
    output blt_ack, blt_rvalid, blt_q,
    output mem_a, mem_we, mem_d, busy
  );

  modport master (
    output uploading, up_req, up_a, up_d,
    output cpu_req, cpu_we, cpu_a, cpu_d,
    output blt_req, blt_we, blt_a, blt_d,
    output mem_q,
    input  up_ack, cpu_ack, cpu_rvalid, cpu_q,
    input  blt_ack, blt_rvalid, blt_q,
    input  mem_a, mem_we, mem_d, busy
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Chip-8 single-port RAM arbiter: uploader has absolute priority and locks
// out CPU/blitter while uploading; CPU and blitter share round-robin.
// Read data returns RD_LAT cycles after ack, tracked by a {valid, owner} shift.
// Optional macro CHIP8_ARB_STATS_EN adds a saturating conflict counter.
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_res,
  chip8_mem_arbiter_if.slave bus
`ifdef CHIP8_ARB_STATS_EN
  ,
  input  logic        i_stats_clr,
  output logic [15:0] o_conflicts
`endif
);

  logic              r_ptr;       // 0: CPU wins next contention, 1: blitter
  logic              r_up_ack, r_cpu_ack, r_blt_ack;
  logic [ADDR_W-1:0] r_mem_a;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_d;
  logic [DATA_W-1:0] r_cpu_q, r_blt_q;
  // Stage 0 lines up with the ack cycle; stage RD_LAT with valid mem_q.
  logic [RD_LAT:0]   r_vld_pipe;
  logic [RD_LAT:0]   r_own_pipe;  // 1: blitter owns the return

  logic              w_up_g, w_cpu_g, w_blt_g, w_any_g, w_contend, w_rd_issue;
  logic              w_we;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_d;
  logic              w_cpu_ret, w_blt_ret;

  // Grant selection: uploader first, lockout while uploading, then round-robin.
  always_comb begin
    w_up_g    = 1'b0;
    w_cpu_g   = 1'b0;
    w_blt_g   = 1'b0;
    w_contend = 1'b0;
    if (bus.up_req) begin
      w_up_g = 1'b1;
    end else if (!bus.uploading) begin
      if (bus.cpu_req && bus.blt_req) begin
        w_contend = 1'b1;
        w_cpu_g   = ~r_ptr;
        w_blt_g   = r_ptr;
      end else begin
        w_cpu_g = bus.cpu_req;
        w_blt_g = bus.blt_req;
      end
    end
  end

  // Winner's address/data/direction mux.
  always_comb begin
    w_a  = bus.up_a;
    w_d  = bus.up_d;
    w_we = 1'b1;
    if (w_cpu_g) begin
      w_a  = bus.cpu_a;
      w_d  = bus.cpu_d;
      w_we = bus.cpu_we;
    end else if (w_blt_g) begin
      w_a  = bus.blt_a;
      w_d  = bus.blt_d;
      w_we = bus.blt_we;
    end
  end

  assign w_any_g    = w_up_g | w_cpu_g | w_blt_g;
  assign w_rd_issue = (w_cpu_g & ~bus.cpu_we) | (w_blt_g & ~bus.blt_we);

  // Returns are suppressed during reset so an in-flight read never surfaces.
  assign w_cpu_ret = r_vld_pipe[RD_LAT] & ~r_own_pipe[RD_LAT] & ~i_res;
  assign w_blt_ret = r_vld_pipe[RD_LAT] &  r_own_pipe[RD_LAT] & ~i_res;

  // Grant registration, RAM command register and read-return tracking.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_ptr      <= 1'b0;
      r_up_ack   <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_blt_ack  <= 1'b0;
      r_mem_a    <= '0;
      r_mem_we   <= 1'b0;
      r_mem_d    <= '0;
      r_cpu_q    <= '0;
      r_blt_q    <= '0;
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
    end else begin
      r_up_ack  <= w_up_g;
      r_cpu_ack <= w_cpu_g;
      r_blt_ack <= w_blt_g;
      r_mem_we  <= w_any_g & w_we;
      if (w_any_g) begin
        r_mem_a <= w_a;
        r_mem_d <= w_d;
      end
      if (w_contend) r_ptr <= ~r_ptr;
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_rd_issue};
      r_own_pipe <= {r_own_pipe[RD_LAT-1:0], w_blt_g};
      if (w_cpu_ret) r_cpu_q <= bus.mem_q;
      if (w_blt_ret) r_blt_q <= bus.mem_q;
    end
  end

  assign bus.up_ack     = r_up_ack;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.blt_ack    = r_blt_ack;
  assign bus.mem_a      = r_mem_a;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_d      = r_mem_d;
  assign bus.cpu_rvalid = w_cpu_ret;
  assign bus.blt_rvalid = w_blt_ret;
  // q shows mem_q in the return cycle itself, then holds it.
  assign bus.cpu_q      = w_cpu_ret ? bus.mem_q : r_cpu_q;
  assign bus.blt_q      = w_blt_ret ? bus.mem_q : r_blt_q;
  assign bus.busy       = r_up_ack | r_cpu_ack | r_blt_ack | (|r_vld_pipe);

`ifdef CHIP8_ARB_STATS_EN
  logic [15:0] r_conflicts;
  logic        w_conflict;

  assign w_conflict = (bus.cpu_req & ~w_cpu_g) | (bus.blt_req & ~w_blt_g);

  // Saturating count of cycles where a CPU/blitter request was left waiting.
  always_ff @(posedge i_clk) begin
    if (i_res || i_stats_clr)                   r_conflicts <= '0;
    else if (w_conflict && r_conflicts != 16'hFFFF) r_conflicts <= r_conflicts + 16'd1;
  end

  assign o_conflicts = r_conflicts;
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) driven by
// identical stimulus, each with its own RAM model and read-return scoreboard.
module tb_chip8_mem_arbiter;
  logic clk = 1'b0;
  logic res;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ifa ();
  chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ifb ();

`ifdef CHIP8_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] conf1, conf3;
`endif

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_res(res), .bus(ifa)
`ifdef CHIP8_ARB_STATS_EN
    , .i_stats_clr(stats_clr), .o_conflicts(conf1)
`endif
  );

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_res(res), .bus(ifb)
`ifdef CHIP8_ARB_STATS_EN
    , .i_stats_clr(stats_clr), .o_conflicts(conf3)
`endif
  );

  // ifb mirrors the requester side of ifa.
  assign ifb.uploading = ifa.uploading;
  assign ifb.up_req    = ifa.up_req;
  assign ifb.up_a      = ifa.up_a;
  assign ifb.up_d      = ifa.up_d;
  assign ifb.cpu_req   = ifa.cpu_req;
  assign ifb.cpu_we    = ifa.cpu_we;
  assign ifb.cpu_a     = ifa.cpu_a;
  assign ifb.cpu_d     = ifa.cpu_d;
  assign ifb.blt_req   = ifa.blt_req;
  assign ifb.blt_we    = ifa.blt_we;
  assign ifb.blt_a     = ifa.blt_a;
  assign ifb.blt_d     = ifa.blt_d;

  // RAM models: synchronous read, latency 1 and 3.
  logic [7:0] ram1 [4096];
  logic [7:0] ram3 [4096];
  logic [7:0] q1p [3];
  logic [7:0] q3p [3];
  always @(posedge clk) begin
    if (ifa.mem_we) ram1[ifa.mem_a] <= ifa.mem_d;
    q1p[0] <= ram1[ifa.mem_a];
    q1p[1] <= q1p[0];
    q1p[2] <= q1p[1];
  end
  always @(posedge clk) begin
    if (ifb.mem_we) ram3[ifb.mem_a] <= ifb.mem_d;
    q3p[0] <= ram3[ifb.mem_a];
    q3p[1] <= q3p[0];
    q3p[2] <= q3p[1];
  end
  assign ifa.mem_q = q1p[0];
  assign ifb.mem_q = q3p[2];

  typedef struct {
    bit         own;   // 1: blitter
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t sb1[$];
  exp_t sb3[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h @cyc %0d", tag, act, exp, cyc);
    end
  endtask

  // Expected return for a read whose request is sampled at the end of cycle n.
  task automatic push(input bit own, input logic [7:0] d, input int n);
    exp_t e;
    e.own = own; e.d = d;
    e.cyc = n + 2; sb1.push_back(e);
    e.cyc = n + 4; sb3.push_back(e);
  endtask

  task automatic sb_take(input int lat, input bit own, input logic [7:0] q);
    exp_t e;
    int   sz;
    sz = (lat == 1) ? sb1.size() : sb3.size();
    if (sz == 0) begin
      chk($sformatf("rv_unexp_l%0d_own%0d", lat, own), sz, 1);
      return;
    end
    e = (lat == 1) ? sb1.pop_front() : sb3.pop_front();
    chk($sformatf("rv_own_l%0d", lat), {31'd0, own}, {31'd0, e.own});
    chk($sformatf("rv_q_l%0d", lat), {24'd0, q}, {24'd0, e.d});
    chk($sformatf("rv_cyc_l%0d", lat), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (ifa.cpu_rvalid) sb_take(1, 1'b0, ifa.cpu_q);
    if (ifa.blt_rvalid) sb_take(1, 1'b1, ifa.blt_q);
    if (ifb.cpu_rvalid) sb_take(3, 1'b0, ifb.cpu_q);
    if (ifb.blt_rvalid) sb_take(3, 1'b1, ifb.blt_q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] pre_a [3];
  logic [7:0]  pre_d [3];

  initial begin
    pre_a[0] = 12'h300; pre_d[0] = 8'h5C;
    pre_a[1] = 12'h010; pre_d[1] = 8'h11;
    pre_a[2] = 12'h020; pre_d[2] = 8'h22;

    res = 1'b1;
    ifa.uploading = 0; ifa.up_req = 0; ifa.up_a = '0; ifa.up_d = '0;
    ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_a = '0; ifa.cpu_d = '0;
    ifa.blt_req = 0; ifa.blt_we = 0; ifa.blt_a = '0; ifa.blt_d = '0;
`ifdef CHIP8_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst_busy1", ifa.busy, 0);     chk("rst_busy3", ifb.busy, 0);
    chk("rst_we1", ifa.mem_we, 0);     chk("rst_a1", ifa.mem_a, 0);
    chk("rst_d1", ifa.mem_d, 0);       chk("rst_cpuq1", ifa.cpu_q, 0);
    chk("rst_bltq3", ifb.blt_q, 0);    chk("rst_acks1", {ifa.up_ack, ifa.cpu_ack, ifa.blt_ack}, 0);
    chk("rst_rv1", {ifa.cpu_rvalid, ifa.blt_rvalid}, 0);
    res = 1'b0;
    tick();

    // Preload RAM contents through the uploader
    ifa.uploading = 1;
    for (int i = 0; i < 3; i++) begin
      ifa.up_req = 1; ifa.up_a = pre_a[i]; ifa.up_d = pre_d[i];
      tick();
      chk("pre_ack", ifa.up_ack, 1);
    end
    ifa.up_req = 0; ifa.uploading = 0;
    tick();

    // Upload burst with the CPU locked out
    ifa.uploading = 1;
    ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_a = 12'h300;
    for (int i = 0; i < 4; i++) begin
      ifa.up_req = 1; ifa.up_a = 12'h200 + 12'(i); ifa.up_d = 8'hA0 + 8'(i);
      tick();
      chk("up_ack", ifa.up_ack, 1);
      chk("up_we", ifa.mem_we, 1);
      chk("up_a", ifa.mem_a, 32'h200 + i);
      chk("up_d", ifa.mem_d, 32'hA0 + i);
      chk("up_cpu_locked", ifa.cpu_ack, 0);
    end
    ifa.up_req = 0;
    tick();
    chk("lock_cpu_ack", ifa.cpu_ack, 0);
    chk("lock_we", ifa.mem_we, 0);
    chk("lock_a_hold", ifa.mem_a, 12'h203);
    chk("lock_d_hold", ifb.mem_d, 8'hA3);
    ifa.uploading = 0;
    push(1'b0, 8'h5C, cyc);
    tick();
    chk("resume_cpu_ack1", ifa.cpu_ack, 1);
    chk("resume_cpu_ack3", ifb.cpu_ack, 1);
    chk("resume_rd_we", ifa.mem_we, 0);
    ifa.cpu_req = 0;
    repeat (5) tick();
    chk("cpuq_hold1", ifa.cpu_q, 8'h5C);
    chk("cpuq_hold3", ifb.cpu_q, 8'h5C);

    // Read back an uploaded byte
    ifa.cpu_req = 1; ifa.cpu_a = 12'h202;
    push(1'b0, 8'hA2, cyc);
    tick();
    chk("rb_ack", ifa.cpu_ack, 1);
    ifa.cpu_req = 0;
    repeat (5) tick();

    // Contention: writes from both, grants alternate starting with CPU
    ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.cpu_a = 12'h400; ifa.cpu_d = 8'h44;
    ifa.blt_req = 1; ifa.blt_we = 1; ifa.blt_a = 12'h500; ifa.blt_d = 8'h55;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_cpu%0d", i), ifa.cpu_ack, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_blt%0d", i), ifb.blt_ack, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_a%0d", i), ifa.mem_a, (i % 2 == 0) ? 12'h400 : 12'h500);
    end
    ifa.cpu_req = 0; ifa.blt_req = 0; ifa.cpu_we = 0; ifa.blt_we = 0;
    repeat (2) tick();

    // Interleaved reads on consecutive grants
    ifa.cpu_req = 1; ifa.cpu_a = 12'h010;
    push(1'b0, 8'h11, cyc);
    tick();
    chk("il_cpu_ack", ifa.cpu_ack, 1);
    ifa.cpu_req = 0;
    ifa.blt_req = 1; ifa.blt_a = 12'h020;
    push(1'b1, 8'h22, cyc);
    tick();
    chk("il_blt_ack", ifb.blt_ack, 1);
    chk("il_busy3", ifb.busy, 1);
    ifa.blt_req = 0;
    tick();
    chk("il_busy3b", ifb.busy, 1);
    repeat (5) tick();
    chk("idle_busy1", ifa.busy, 0);
    chk("idle_busy3", ifb.busy, 0);
    chk("il_bltq3", ifb.blt_q, 8'h22);

    // Upload session starts while a read is in flight; blitter locked out
    ifa.cpu_req = 1; ifa.cpu_a = 12'h300;
    push(1'b0, 8'h5C, cyc);
    tick();
    chk("fl_cpu_ack", ifa.cpu_ack, 1);
    ifa.cpu_req = 0; ifa.uploading = 1;
    ifa.blt_req = 1; ifa.blt_we = 1; ifa.blt_a = 12'h600; ifa.blt_d = 8'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_blt_locked", ifa.blt_ack, 0);
    end
    ifa.uploading = 0;
    tick();
    chk("fl_blt_resume", ifa.blt_ack, 1);
    ifa.blt_req = 0; ifa.blt_we = 0;
    repeat (3) tick();

    // Reset while a read is in flight: no return, outputs cleared
    ifa.cpu_req = 1; ifa.cpu_a = 12'h010;
    tick();
    chk("rm_ack", ifa.cpu_ack, 1);
    ifa.cpu_req = 0;
    tick();
    res = 1'b1;
    tick();
    chk("rm_busy1", ifa.busy, 0);
    chk("rm_busy3", ifb.busy, 0);
    chk("rm_we3", ifb.mem_we, 0);
    chk("rm_cpuq3", ifb.cpu_q, 0);
    res = 1'b0;
    repeat (6) tick();

`ifdef CHIP8_ARB_STATS_EN
    stats_clr = 1;
    tick();
    stats_clr = 0;
    chk("st_clr0", conf1, 0);
    ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.blt_req = 1; ifa.blt_we = 1;
    repeat (10) tick();
    chk("st_ten1", conf1, 10);
    chk("st_ten3", conf3, 10);
    ifa.cpu_req = 0; ifa.blt_req = 0;
    tick();
    chk("st_hold", conf1, 10);
    stats_clr = 1;
    tick();
    stats_clr = 0;
    chk("st_clr", conf1, 0);
    ifa.cpu_req = 1; ifa.blt_req = 1;
    repeat (65534) tick();
    chk("st_fffe", conf1, 16'hFFFE);
    repeat (3) tick();
    chk("st_sat", conf1, 16'hFFFF);
    ifa.cpu_req = 0; ifa.blt_req = 0; ifa.cpu_we = 0; ifa.blt_we = 0;
    tick();
`endif

    repeat (4) tick();
    chk("sb1_empty", sb1.size(), 0);
    chk("sb3_empty", sb3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
